key_expansion: RTL and testbench

KEY_EXPANSION -- requirements
Module: key_expansion

---
 rtl/key_expansion.sv | 91 +++++++++
 tb/tb_key_expansion.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/key_expansion.sv
// key_expansion: AES-128 key schedule producing round keys 0..10 one per acknowledged cycle.
// Ports:
//   clk        rising-edge clock for all state
//   reset      synchronous active-high reset
//   start      begin expansion of key (taken only while ready)
//   key        128-bit cipher key, w0 in [127:96]
//   sboxw      RotWord(w3) sent to the external SubWord S-box
//   new_sboxw  SubWord(sboxw) returned combinationally
//   round_key  current round key, same word order as key
//   round_idx  index 0..10 of round_key
//   key_valid  round_key/round_idx valid
//   key_ack    consumer takes the current round key
//   ready      idle, start accepted
//   done       one-cycle pulse after round key 10 is taken
module key_expansion (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    input  logic         key_ack,
    output logic         ready,
    output logic         done
);
    typedef enum logic {IDLE, EXPAND} state_t;
    state_t       r_state, w_state_nxt;
    logic [127:0] r_key, w_key_nxt;
    logic [3:0]   r_idx, w_idx_nxt;
    logic         r_done, w_done_nxt;
    logic         w_ack, w_last;
    logic [7:0]   w_rcon;
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    always_comb begin
        w_ack  = (r_state == EXPAND) && key_ack;
        w_last = (r_idx == 4'd10);
        // rcon belongs to the round being produced, i.e. r_idx + 1
        w_rcon = (r_idx == 4'd0) ? 8'h01 :
                 (r_idx == 4'd1) ? 8'h02 :
                 (r_idx == 4'd2) ? 8'h04 :
                 (r_idx == 4'd3) ? 8'h08 :
                 (r_idx == 4'd4) ? 8'h10 :
                 (r_idx == 4'd5) ? 8'h20 :
                 (r_idx == 4'd6) ? 8'h40 :
                 (r_idx == 4'd7) ? 8'h80 :
                 (r_idx == 4'd8) ? 8'h1b :
                 (r_idx == 4'd9) ? 8'h36 : 8'h00;
        w_w0 = r_key[127:96] ^ new_sboxw ^ {w_rcon, 24'h0};
        w_w1 = r_key[95:64] ^ w_w0;
        w_w2 = r_key[63:32] ^ w_w1;
        w_w3 = r_key[31:0]  ^ w_w2;
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        if (r_state == IDLE && start) begin
            w_state_nxt = EXPAND;
            w_key_nxt   = key;
            w_idx_nxt   = 4'd0;
        end else if (w_ack && w_last) begin
            // key and index stay on round 10 after the final handshake
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
        end else if (w_ack) begin
            w_key_nxt = {w_w0, w_w1, w_w2, w_w3};
            w_idx_nxt = r_idx + 4'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_key   <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
        end
    end
    assign sboxw     = {r_key[23:0], r_key[31:24]};
    assign round_key = r_key;
    assign round_idx = r_idx;
    assign key_valid = (r_state == EXPAND);
    assign ready     = (r_state == IDLE);
    assign done      = r_done;
endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion: scoreboard bench for key_expansion against a word-level AES key schedule model.
module tb_key_expansion;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic [31:0]  sboxw, new_sboxw;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid, key_ack = 1'b0, ready, done;
    int checks = 0, failures = 0;
    bit mon_en = 1'b0;
    logic [7:0] sb [256];
    typedef struct { logic [127:0] k; logic [3:0] idx; } exp_t;
    exp_t sb_q[$];
    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key_expansion dut (
        .clk(clk), .reset(reset), .start(start), .key(key),
        .sboxw(sboxw), .new_sboxw(new_sboxw),
        .round_key(round_key), .round_idx(round_idx), .key_valid(key_valid),
        .key_ack(key_ack), .ready(ready), .done(done)
    );
    always #5 clk = ~clk;
    assign new_sboxw = {sb[sboxw[31:24]], sb[sboxw[23:16]], sb[sboxw[15:8]], sb[sboxw[7:0]]};
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            hi = a[7];
            a = {a[6:0], 1'b0} ^ (hi ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction
    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction
    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction
    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            x = a[7:0];
            for (int y = 1; y < 256 && a != 0; y++)
                if (gm(x, y[7:0]) == 8'h01) inv = y[7:0];
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask
    // FIPS-197 word recurrence over w[0..43]
    task automatic model(input logic [127:0] k, output logic [127:0] rk [11]);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask
    // monitor: every valid cycle must show the scoreboard head; handshakes pop it
    bit pend_done = 1'b0;
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            chk("done", {127'h0, done}, {127'h0, pend_done});
            pend_done = 1'b0;
            if (key_valid) begin
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_key got=%h idx=%0d", round_key, round_idx);
                end else begin
                    chk("round_key", round_key, sb_q[0].k);
                    chk("round_idx", {124'h0, round_idx}, {124'h0, sb_q[0].idx});
                    chk("sboxw", {96'h0, sboxw}, {96'h0, sb_q[0].k[23:0], sb_q[0].k[31:24]});
                    if (key_ack) begin
                        pend_done = (sb_q[0].idx == 4'd10);
                        void'(sb_q.pop_front());
                    end
                end
            end
        end else pend_done = 1'b0;
    end
    task automatic run_key(input logic [127:0] k, input int ack_pct, input bit hold3,
                           input bit spam, input bit fin_start, input bit rst5);
        logic [127:0] rk [11];
        int hc = 0;
        bit done_seen = 1'b0;
        model(k, rk);
        if (k == K_FIPS) begin
            rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
            rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
            rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        end
        if (k == '0) begin
            rk[1]  = 128'h62636363626363636263636362636363;
            rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        end
        chk("ready_before_start", {127'h0, ready}, 128'h1);
        start = 1'b1;
        key = k;
        key_ack = ($urandom_range(99) < ack_pct);
        for (int r = 0; r < 11; r++) sb_q.push_back('{rk[r], r[3:0]});
        @(posedge clk); #1;
        start = 1'b0;
        key = {$urandom, $urandom, $urandom, $urandom};
        chk("valid_after_start", {127'h0, key_valid}, 128'h1);
        chk("ready_after_start", {127'h0, ready}, 128'h0);
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (rst5 && key_valid && round_idx == 4'd5) begin
                reset = 1'b1;
                start = 1'b1;
                key_ack = $urandom_range(1);
                @(posedge clk); #1;
                reset = 1'b0;
                start = 1'b0;
                sb_q.delete();
                chk("rst_valid", {127'h0, key_valid}, 128'h0);
                chk("rst_ready", {127'h0, ready}, 128'h1);
                chk("rst_key", round_key, 128'h0);
                chk("rst_idx", {124'h0, round_idx}, 128'h0);
                repeat (12) @(posedge clk);
                #1;
                return;
            end
            if (hold3 && round_idx == 4'd3 && hc < 5) begin
                key_ack = 1'b0;
                hc++;
            end else key_ack = ($urandom_range(99) < ack_pct);
            if (spam) begin
                start = $urandom_range(1);
                key = {$urandom, $urandom, $urandom, $urandom};
            end
            if (fin_start && round_idx == 4'd10 && key_ack) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                done_seen = 1'b1;
                break;
            end
        end
        if (!done_seen) begin
            checks++; failures++;
            $display("FAIL expansion_timeout got=no_done exp=done");
        end
        chk("end_ready", {127'h0, ready}, 128'h1);
        chk("end_valid", {127'h0, key_valid}, 128'h0);
        chk("end_idx", {124'h0, round_idx}, 128'd10);
        chk("end_key", round_key, rk[10]);
        chk("end_queue", 128'(sb_q.size()), 128'h0);
        key_ack = $urandom_range(1);
        @(posedge clk); #1;
        chk("idle_after_done", {127'h0, ready}, 128'h1);
    endtask
    initial begin
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready0", {127'h0, ready}, 128'h1);
        chk("rst_valid0", {127'h0, key_valid}, 128'h0);
        chk("rst_done0", {127'h0, done}, 128'h0);
        chk("rst_idx0", {124'h0, round_idx}, 128'h0);
        chk("rst_key0", round_key, 128'h0);
        reset = 1'b0;
        mon_en = 1'b1;
        run_key(K_FIPS, 100, 0, 0, 0, 0);
        run_key(K_FIPS, 100, 1, 0, 0, 0);
        run_key('0, 100, 0, 0, 0, 0);
        run_key(K_FIPS, 100, 0, 1, 1, 0);
        run_key(K_FIPS, 100, 0, 0, 0, 1);
        run_key(K_FIPS, 100, 0, 0, 0, 0);
        for (int n = 0; n < 6; n++)
            run_key({$urandom, $urandom, $urandom, $urandom}, 60, 0, 1, 1, 0);
        run_key({$urandom, $urandom, $urandom, $urandom}, 70, 0, 0, 0, 1);
        run_key({$urandom, $urandom, $urandom, $urandom}, 50, 1, 1, 0, 0);
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
